// File: rtl/nzcv_pkg.sv
// Shared types for the NZCV flag pipeline: condition codes, flag nibble, pipeline slot.
package nzcv_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic  valid;
    logic  setflags;
    nzcv_t nzcv;
  } flag_slot_t;

  localparam nzcv_t      NZCV_ZERO  = '0;
  localparam flag_slot_t SLOT_EMPTY = '0;

  function automatic logic slot_live(input flag_slot_t s);
    return s.valid & s.setflags;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// AArch64 condition-code decode: one flag nibble plus cond -> taken.
module cond_eval
  import nzcv_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = ~flags.z;
      COND_CS: taken = flags.c;
      COND_CC: taken = ~flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = ~flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = ~flags.v;
      COND_HI: taken = flags.c & ~flags.z;
      COND_LS: taken = ~flags.c | flags.z;
      COND_GE: taken = (flags.n == flags.v);
      COND_LT: taken = (flags.n != flags.v);
      COND_GT: taken = ~flags.z & (flags.n == flags.v);
      COND_LE: taken = flags.z | (flags.n != flags.v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/nzcv_unit.sv
// EX/MEM/WB flag pipeline with speculative/committed NZCV and B.cond resolution.
// Define NZCV_FLAG_BYPASS_EN to let a branch use live ALU flags instead of stalling.
module nzcv_unit
  import nzcv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_setflags,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  input  logic       stall,
  input  logic       flush,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  output logic [3:0] spec_nzcv,
  output logic [3:0] arch_nzcv,
  output logic       cond_taken,
  output logic       cond_ready,
  output logic       cond_stall
);

  flag_slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  nzcv_t      spec_q, spec_d, arch_q, arch_d;
  nzcv_t      alu_flags, post_commit, br_flags;
  logic       ex_live, commit, br_hazard, eval_taken;

  always_comb begin
    alu_flags   = '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
    ex_live     = ex_valid & ex_setflags;
    commit      = slot_live(wb_q);
    post_commit = commit ? wb_q.nzcv : arch_q;

    ex_d   = ex_q;
    mem_d  = mem_q;
    wb_d   = wb_q;
    spec_d = spec_q;
    arch_d = post_commit;

    if (flush) begin
      // MEM is killed, so nothing younger than the current WB ever reaches WB.
      ex_d   = SLOT_EMPTY;
      mem_d  = SLOT_EMPTY;
      wb_d   = SLOT_EMPTY;
      spec_d = post_commit;
    end else if (stall) begin
      // WB retires during the stall; drop it so it cannot commit a second time.
      if (commit) wb_d.valid = 1'b0;
    end else begin
      ex_d  = '{valid: ex_valid, setflags: ex_setflags, nzcv: alu_flags};
      mem_d = ex_q;
      wb_d  = mem_q;
      if (ex_live) spec_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= SLOT_EMPTY;
      mem_q  <= SLOT_EMPTY;
      wb_q   <= SLOT_EMPTY;
      spec_q <= NZCV_ZERO;
      arch_q <= NZCV_ZERO;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      spec_q <= spec_d;
      arch_q <= arch_d;
    end
  end

  always_comb begin
`ifdef NZCV_FLAG_BYPASS_EN
    br_hazard = 1'b0;
    br_flags  = ex_live ? alu_flags : spec_q;
`else
    br_hazard = br_valid & ex_live;
    br_flags  = spec_q;
`endif
    if (reset) begin
      br_hazard = 1'b0;
      br_flags  = NZCV_ZERO;
    end
  end

  cond_eval u_cond_eval (
    .flags (br_flags),
    .cond  (cond_e'(br_cond)),
    .taken (eval_taken)
  );

  assign spec_nzcv  = spec_q;
  assign arch_nzcv  = arch_q;
  assign cond_stall = br_hazard;
  assign cond_ready = br_valid & ~br_hazard;
  assign cond_taken = cond_ready & eval_taken;

endmodule

// File: tb/tb_nzcv_unit.sv
// Self-checking bench for nzcv_unit: directed scenarios, full cond sweep, random traffic
// against a queue-based model of in-flight flag writers.
module tb_nzcv_unit;

  logic       clk = 1'b0;
  logic       reset, ex_valid, ex_setflags;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       stall, flush, br_valid;
  logic [3:0] br_cond;
  logic [3:0] spec_nzcv, arch_nzcv;
  logic       cond_taken, cond_ready, cond_stall;

  int checks = 0;
  int errors = 0;

  nzcv_unit dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_cond(br_cond), .spec_nzcv(spec_nzcv), .arch_nzcv(arch_nzcv),
    .cond_taken(cond_taken), .cond_ready(cond_ready), .cond_stall(cond_stall)
  );

  always #5 clk = ~clk;

  // In-flight flag writers, oldest first; age 1=EX, 2=MEM, 3=WB.
  typedef struct {
    logic [3:0] f;
    int         age;
  } ent_t;
  ent_t       q[$];
  logic [3:0] m_arch;

  function automatic logic [3:0] m_spec();
    if (q.size() > 0) return q[q.size()-1].f;
    return m_arch;
  endfunction

  // ConditionHolds-style evaluation: base test from cond[3:1], inverted by cond[0].
  function automatic logic holds(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if (c[0] && c != 4'hF) r = !r;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit st, input bit fl, input bit exv,
                       input bit exsf, input logic [3:0] alu, input bit brv,
                       input logic [3:0] brc);
    reset = rst; stall = st; flush = fl;
    ex_valid = exv; ex_setflags = exsf;
    {alu_negative, alu_zero, alu_carry_out, alu_overflow} = alu;
    br_valid = brv; br_cond = brc;
    #3;
  endtask

  task automatic model_edge();
    logic [3:0] alu;
    alu = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    if (reset) begin
      q.delete();
      m_arch = 4'b0000;
    end else begin
      if (q.size() > 0 && q[0].age == 3) begin
        m_arch = q[0].f;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (!stall) begin
        foreach (q[i]) q[i].age++;
        if (ex_valid && ex_setflags) q.push_back('{f: alu, age: 1});
      end
    end
  endtask

  // Compare every output against the model, then take the clock edge.
  task automatic fin();
    logic       haz, rdy, tk;
    logic [3:0] fl;
    haz = br_valid && ex_valid && ex_setflags && !reset;
`ifdef NZCV_FLAG_BYPASS_EN
    fl  = reset ? 4'b0000 : (haz ? {alu_negative, alu_zero, alu_carry_out, alu_overflow} : m_spec());
    haz = 1'b0;
`else
    fl  = reset ? 4'b0000 : m_spec();
`endif
    rdy = br_valid && !haz;
    tk  = rdy && holds(fl, br_cond);
    chk("m_spec", spec_nzcv, m_spec());
    chk("m_arch", arch_nzcv, m_arch);
    chk("m_stall", {3'b0, cond_stall}, {3'b0, haz});
    chk("m_ready", {3'b0, cond_ready}, {3'b0, rdy});
    chk("m_taken", {3'b0, cond_taken}, {3'b0, tk});
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
      fin();
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 4'h0, 0, 4'h0);
    fin();
  endtask

  initial begin
    m_arch = 4'b0000;
    // First reset edge: state is unknown before it, so only clock it.
    drive(1, 0, 0, 0, 0, 4'h0, 0, 4'h0);
    @(posedge clk);
    #1;
    model_edge();

    // Reset cycle: branch sees zero flags, no stall even with a live setflags op.
    drive(1, 1, 1, 1, 1, 4'hF, 1, 4'h1);
    chk("rst_stall", {3'b0, cond_stall}, 4'd0);
    chk("rst_ne_taken", {3'b0, cond_taken}, 4'd1);
    fin();
    drive(1, 0, 0, 1, 1, 4'hF, 1, 4'h0);
    chk("rst_eq_taken", {3'b0, cond_taken}, 4'd0);
    chk("rst_eq_ready", {3'b0, cond_ready}, 4'd1);
    fin();
    chk("rst_spec", spec_nzcv, 4'b0000);
    chk("rst_arch", arch_nzcv, 4'b0000);

    // SUBS Z=1,C=1 then B.EQ the next cycle.
    drive(0, 0, 0, 1, 1, 4'b0110, 0, 4'h0); fin();
    drive(0, 0, 0, 0, 0, 4'h0, 1, 4'h0);
    chk("subs_spec", spec_nzcv, 4'b0110);
    chk("subs_eq_taken", {3'b0, cond_taken}, 4'd1);
    fin();
    idle(1);
    chk("subs_arch_early", arch_nzcv, 4'b0000);
    idle(1);
    chk("subs_arch", arch_nzcv, 4'b0110);

    // SUBS N=1,V=0 with same-cycle B.LT.
    drive(0, 0, 0, 1, 1, 4'b1000, 1, 4'hB);
`ifdef NZCV_FLAG_BYPASS_EN
    chk("lt_stall", {3'b0, cond_stall}, 4'd0);
    chk("lt_taken", {3'b0, cond_taken}, 4'd1);
`else
    chk("lt_stall", {3'b0, cond_stall}, 4'd1);
    chk("lt_ready", {3'b0, cond_ready}, 4'd0);
`endif
    fin();
    drive(0, 0, 0, 0, 0, 4'h0, 1, 4'hB);
    chk("lt_stall_next", {3'b0, cond_stall}, 4'd0);
    chk("lt_taken_next", {3'b0, cond_taken}, 4'd1);
    fin();
    idle(3);

    // ADDS with V=1, flushed next cycle: spec falls back to arch.
    do_reset();
    drive(0, 0, 0, 1, 1, 4'b0001, 0, 4'h0); fin();
    drive(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
    chk("flush_spec_pre", spec_nzcv, 4'b0001);
    fin();
    chk("flush_spec", spec_nzcv, 4'b0000);
    idle(4);
    chk("flush_arch", arch_nzcv, 4'b0000);

    // Stall three cycles with a setflags op in MEM.
    drive(0, 0, 0, 1, 1, 4'b1010, 0, 4'h0); fin();
    idle(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 4'h0, 0, 4'h0);
      fin();
      chk("stall_arch_hold", arch_nzcv, 4'b0000);
    end
    idle(1);
    chk("stall_arch_wb", arch_nzcv, 4'b0000);
    idle(1);
    chk("stall_arch_commit", arch_nzcv, 4'b1010);

    // Reset with all three slots holding setflags ops.
    drive(0, 0, 0, 1, 1, 4'b1111, 0, 4'h0); fin();
    drive(0, 0, 0, 1, 1, 4'b0101, 0, 4'h0); fin();
    drive(0, 0, 0, 1, 1, 4'b0011, 0, 4'h0); fin();
    drive(1, 1, 1, 0, 0, 4'h0, 0, 4'h0); fin();
    chk("midrst_spec", spec_nzcv, 4'b0000);
    chk("midrst_arch", arch_nzcv, 4'b0000);
    idle(4);
    chk("midrst_no_commit", arch_nzcv, 4'b0000);

    // Full cond x flags sweep.
    for (int f = 0; f < 16; f++) begin
      drive(0, 0, 0, 1, 1, 4'(f), 0, 4'h0); fin();
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, 0, 0, 0, 4'h0, 1, 4'(c));
        if (c >= 14) chk("al_nv_taken", {3'b0, cond_taken}, 4'd1);
        fin();
      end
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom), 4'($urandom));
      fin();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
